// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step clock-enable controller for the nanoMIPS core.
// Issues cpu_ce in free-run, run-N or run-to-breakpoint modes with a prescaler.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   mode            00 halt, 01 free run, 10 run N, 11 run to breakpoint
//   start, abort    run request / stop current run
//   step_count      N for run-N mode
//   bp_addr, bp_en  breakpoint PC and compare enable
//   div             one CE every div+1 clocks
//   pc              current core PC
//   cpu_ce          core clock enable (combinational)
//   running, done   in RUN / one-cycle end-of-run pulse
//   halt_reason     0 none, 1 count, 2 breakpoint, 3 abort
//   cycle_cnt       CEs issued in current or last run
module cpu_run_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  step_count,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_en,
  input  logic [DIV_W-1:0]  div,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_ce,
  output logic              running,
  output logic              done,
  output logic [1:0]        halt_reason,
  output logic [CNT_W-1:0]  cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] M_HALT = 2'b00;
  localparam logic [1:0] M_FREE = 2'b01;
  localparam logic [1:0] M_CNT  = 2'b10;
  localparam logic [1:0] M_BP   = 2'b11;

  state_t             state;
  logic [1:0]         mode_q;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   n_q;
  logic               ce_seen;

  logic               tick;
  logic               bp_mode;
  logic               bp_hit;
  logic               n_zero;
  logic               last_ce;
  logic               stop;
  logic [1:0]         reason;

  assign tick    = (state == RUN) && (div_cnt == div_q);
  assign bp_mode = (mode_q == M_FREE) || (mode_q == M_BP);

  // ce_seen lets a run resume from a PC sitting on the breakpoint
  assign bp_hit  = bp_mode && bp_en && (pc == bp_addr) && ce_seen;

  // run-N with N=0 ends on the first RUN cycle without any CE
  assign n_zero  = (mode_q == M_CNT) && (n_q == '0);

  assign cpu_ce  = tick && !abort && !bp_hit && !n_zero;

  assign last_ce = cpu_ce && (mode_q == M_CNT) &&
                   ((cycle_cnt + CNT_W'(1)) == n_q);

  always_comb begin
    stop   = 1'b0;
    reason = 2'd0;
    if (abort) begin
      stop   = 1'b1;
      reason = 2'd3;
    end else if (tick && bp_hit) begin
      stop   = 1'b1;
      reason = 2'd2;
    end else if (last_ce || n_zero) begin
      stop   = 1'b1;
      reason = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= M_HALT;
      div_q       <= '0;
      div_cnt     <= '0;
      n_q         <= '0;
      ce_seen     <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      halt_reason <= 2'd0;
      cycle_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && (mode != M_HALT)) begin
            state       <= RUN;
            running     <= 1'b1;
            mode_q      <= mode;
            div_q       <= div;
            n_q         <= step_count;
            div_cnt     <= '0;
            cycle_cnt   <= '0;
            halt_reason <= 2'd0;
            ce_seen     <= 1'b0;
          end
        end
        RUN: begin
          div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
          if (cpu_ce) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            ce_seen   <= 1'b1;
          end
          if (stop) begin
            state       <= DONE;
            running     <= 1'b0;
            done        <= 1'b1;
            halt_reason <= reason;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scoreboard bench for cpu_run_ctrl.
// Runs are predicted arithmetically and checked by a separate monitor.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        start;
  logic        abort;
  logic [31:0] step_count;
  logic [31:0] bp_addr;
  logic        bp_en;
  logic [7:0]  div;
  logic [31:0] pc;
  logic        cpu_ce;
  logic        running;
  logic        done;
  logic [1:0]  halt_reason;
  logic [31:0] cycle_cnt;

  cpu_run_ctrl #(
    .ADDR_W(32),
    .CNT_W (32),
    .DIV_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .start      (start),
    .abort      (abort),
    .step_count (step_count),
    .bp_addr    (bp_addr),
    .bp_en      (bp_en),
    .div        (div),
    .pc         (pc),
    .cpu_ce     (cpu_ce),
    .running    (running),
    .done       (done),
    .halt_reason(halt_reason),
    .cycle_cnt  (cycle_cnt)
  );

  typedef struct {
    int ces;
    int reason;
    int done_rc;
    int p;
  } exp_t;

  exp_t sbq[$];

  int checks;
  int errors;
  int cyc;
  int c0;
  int ce_count;
  int ndone;
  logic ce_now;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // core model: PC steps by 4 after every issued CE
  always begin
    @(negedge clk);
    ce_now = cpu_ce;
    @(posedge clk);
    #1;
    if (ce_now && rst_n) pc = pc + 32'd4;
  end

  // monitor: checks CE phase, running, and end-of-run results
  int   mrc;
  exp_t me;
  always @(negedge clk) begin
    mrc = cyc - c0;
    if (sbq.size() > 0) begin
      chk("running", {63'd0, running},
          {63'd0, (mrc < sbq[0].done_rc)});
      if (cpu_ce) begin
        ce_count++;
        chk("ce_phase", 64'(mrc % sbq[0].p), 64'd0);
      end
      if (done) begin
        me = sbq.pop_front();
        chk("cycle_cnt", {32'd0, cycle_cnt}, 64'(me.ces));
        chk("halt_reason", {62'd0, halt_reason}, 64'(me.reason));
        chk("ce_count", 64'(ce_count), 64'(me.ces));
        chk("done_time", 64'(mrc), 64'(me.done_rc));
        ndone++;
      end
    end else begin
      chk("ce_idle", {63'd0, cpu_ce}, 64'd0);
      chk("done_idle", {63'd0, done}, 64'd0);
    end
  end

  // Predict a run from the rules, drive it and wait for its end.
  task automatic run_one(input logic [1:0] m, input int dv, input int n,
                         input logic be, input logic [31:0] bp,
                         input logic [31:0] pc0, input int ab);
    exp_t e;
    int   p;
    int   big_e;
    bit   inf;
    bit   found;
    int   nd0;
    int   rc;
    p     = dv + 1;
    inf   = 1'b1;
    found = 1'b0;
    big_e = 0;
    e.ces = 0;
    e.reason = 0;
    if (m == 2'b10) begin
      inf = 1'b0;
      e.reason = 1;
      if (n == 0) begin
        big_e = 1;
        e.ces = 0;
      end else begin
        big_e = n * p;
        e.ces = n;
      end
    end else if (be) begin
      for (int k = 1; k <= 200; k++) begin
        if (!found && (pc0 + 32'(4 * k)) == bp) begin
          found = 1'b1;
          inf = 1'b0;
          big_e = (k + 1) * p;
          e.ces = k;
          e.reason = 2;
        end
      end
    end
    if (ab > 0 && (inf || ab <= big_e)) begin
      big_e = ab;
      e.ces = (ab - 1) / p;
      e.reason = 3;
      inf = 1'b0;
    end
    if (inf) begin
      big_e = 40;
      ab = 40;
      e.ces = 39 / p;
      e.reason = 3;
    end
    e.done_rc = big_e + 1;
    e.p = p;
    mode = m;
    div = 8'(dv);
    step_count = 32'(n);
    bp_en = be;
    bp_addr = bp;
    pc = pc0;
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc - 1;
    ce_count = 0;
    nd0 = ndone;
    sbq.push_back(e);
    start = 1'b0;
    mode = 2'($urandom);
    div = 8'($urandom);
    step_count = $urandom;
    forever begin
      rc = cyc - c0;
      abort = (rc == ab);
      if (ndone != nd0 || rc > big_e + 5) break;
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    chk("run_finished", 64'(ndone - nd0), 64'd1);
    sbq.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int dv, n, ab;
  logic [1:0]  m;
  logic        be;
  logic [31:0] pc0;
  logic [31:0] bp;

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    c0 = 0;
    ce_count = 0;
    ndone = 0;
    rst_n = 1'b0;
    mode = 2'b00;
    start = 1'b0;
    abort = 1'b0;
    step_count = '0;
    bp_addr = '0;
    bp_en = 1'b0;
    div = '0;
    pc = '0;
    #1;
    chk("rst_ce", {63'd0, cpu_ce}, 64'd0);
    chk("rst_running", {63'd0, running}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_reason", {62'd0, halt_reason}, 64'd0);
    chk("rst_cnt", {32'd0, cycle_cnt}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_one(2'b10, 0, 4, 1'b0, 32'h0, 32'h0, 0);
    run_one(2'b10, 2, 3, 1'b0, 32'h0, 32'h0, 0);
    run_one(2'b11, 0, 0, 1'b1, 32'h0C, 32'h0, 0);
    run_one(2'b11, 0, 0, 1'b1, 32'h0C, 32'h0C, 8);
    run_one(2'b01, 1, 0, 1'b0, 32'h0, 32'h0, 4);
    run_one(2'b10, 0, 0, 1'b0, 32'h0, 32'h0, 0);
    run_one(2'b10, 1, 3, 1'b1, 32'h10, 32'h10, 0);

    mode = 2'b00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("halt_running", {63'd0, running}, 64'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      m   = 2'($urandom_range(1, 3));
      dv  = $urandom_range(0, 3);
      n   = $urandom_range(0, 6);
      be  = 1'($urandom_range(0, 1));
      pc0 = 32'(4 * $urandom_range(0, 15));
      bp  = pc0 + 32'(4 * $urandom_range(0, 5));
      if (m != 2'b10) ab = $urandom_range(1, 40);
      else ab = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 30);
      run_one(m, dv, n, be, bp, pc0, ab);
    end

    mode = 2'b01;
    div = 8'd0;
    bp_en = 1'b0;
    pc = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc - 1;
    ce_count = 0;
    sbq.push_back('{ces: 0, reason: 0, done_rc: 1000000, p: 1});
    start = 1'b0;
    for (int t = 0; t < 50 && ce_count < 5; t++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_ces", 64'(ce_count), 64'd5);
    rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("mid_rst_ce", {63'd0, cpu_ce}, 64'd0);
    chk("mid_rst_running", {63'd0, running}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_reason", {62'd0, halt_reason}, 64'd0);
    chk("mid_rst_cnt", {32'd0, cycle_cnt}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
